trojan_out_monitor: RTL

- Sits directly downstream of AES_top and consumes both of its outputs: `out` (clean ciphertext) and `destroy_trojan_out` (trojan-path ciphertext).
- A pipelined valid tag, delayed to align with AES_top latency, selects which cycles are compared.
- Each compared cycle is checked for divergence: the XOR difference and its Hamming weight are captured, and mismatches are counted.
- A sticky alarm is raised once a programmable mismatch threshold is reached, giving the bench and on-chip logic a single trojan-activation indicator.

---
 rtl/trojan_out_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/trojan_out_monitor.sv
`default_nettype none
// ============================================================================
// Module   : trojan_out_monitor
// Purpose  : Compares the clean and trojan-path ciphertexts of AES_top on
//            cycles selected by a latency-aligned valid tag. Captures the XOR
//            difference and its Hamming weight on mismatches, keeps saturating
//            sample / mismatch counters and raises a sticky alarm once the
//            mismatch count reaches THRESH.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            in_valid                - stimulus applied to AES_top this cycle
//            out, destroy_trojan_out - clean / trojan ciphertexts (128 bit)
//            clear                   - synchronous clear of counters/captures
//            cmp_valid, mismatch     - registered compare pulse and result
//            diff, diff_hw           - last mismatching XOR and its popcount
//            sample_cnt, mismatch_cnt- saturating counters (CNT_W bits)
//            alarm, state_o          - sticky alarm, FSM state (0/1/2)
// Revision : 1.0 - initial release
// ============================================================================
module trojan_out_monitor #(
    parameter int LATENCY = 1,
    parameter int THRESH  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [127:0]       out,
    input  logic [127:0]       destroy_trojan_out,
    input  logic               clear,
    output logic               cmp_valid,
    output logic               mismatch,
    output logic [127:0]       diff,
    output logic [7:0]         diff_hw,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic               alarm,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);

    state_t             state_q, state_d;
    logic               cmp_valid_q;
    logic               mismatch_q;
    logic [127:0]       diff_q;
    logic [7:0]         diff_hw_q;
    logic [CNT_W-1:0]   sample_cnt_q;
    logic [CNT_W-1:0]   mismatch_cnt_q;

    logic               aligned_v;
    logic               do_cmp;
    logic               neq;
    logic [127:0]       xor_w;
    logic [7:0]         pop_w;
    logic [CNT_W-1:0]   sample_inc;
    logic [CNT_W-1:0]   mismatch_inc;
    logic               thresh_hit;

    // Valid tag delay line. Reset flushes it; clear deliberately does not,
    // so samples already in flight still get compared after a clear.
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign aligned_v = in_valid;
        end else begin : g_delay
            logic [LATENCY-1:0] vpipe_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vpipe_q <= '0;
                end else begin
                    vpipe_q[0] <= in_valid;
                    for (int i = 1; i < LATENCY; i++) begin
                        vpipe_q[i] <= vpipe_q[i-1];
                    end
                end
            end
            assign aligned_v = vpipe_q[LATENCY-1];
        end
    endgenerate

    // A compare coinciding with clear is discarded entirely.
    assign do_cmp = aligned_v & ~clear;
    assign xor_w  = out ^ destroy_trojan_out;
    assign neq    = |xor_w;

    // Popcount is written as a plain sum; synthesis balances it into an
    // adder tree, which keeps it within one cycle at the target clock.
    always_comb begin
        pop_w = '0;
        for (int i = 0; i < 128; i++) begin
            pop_w = pop_w + 8'(xor_w[i]);
        end
    end

    assign sample_inc   = (sample_cnt_q   == c_CNT_MAX) ? sample_cnt_q
                                                        : sample_cnt_q + 1'b1;
    assign mismatch_inc = (mismatch_cnt_q == c_CNT_MAX) ? mismatch_cnt_q
                                                        : mismatch_cnt_q + 1'b1;

    // Alarm fires on the edge whose post-increment mismatch count equals THRESH.
    assign thresh_hit = do_cmp & neq & (mismatch_inc == c_THRESH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (do_cmp) begin
                    state_d = thresh_hit ? ST_ALARM : ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (thresh_hit) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                state_d = ST_ALARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cmp_valid_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            diff_q         <= '0;
            diff_hw_q      <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            cmp_valid_q <= aligned_v;
            if (aligned_v) begin
                mismatch_q   <= neq;
                sample_cnt_q <= sample_inc;
                if (neq) begin
                    diff_q         <= xor_w;
                    diff_hw_q      <= pop_w;
                    mismatch_cnt_q <= mismatch_inc;
                end
            end
        end
    end

    assign cmp_valid    = cmp_valid_q;
    assign mismatch     = mismatch_q;
    assign diff         = diff_q;
    assign diff_hw      = diff_hw_q;
    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign alarm        = (state_q == ST_ALARM);
    assign state_o      = state_q;

endmodule
`default_nettype wire
